// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game video path.
// Game state, grid geometry, palette and 640x480@60 timing.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_RUNNING = 2'b00,
    ST_DIE     = 2'b01,
    ST_INITIAL = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam int COLS = 32;
  localparam int ROWS = 24;
  localparam int CELL = 20;
  localparam logic [4:0] CELL_LAST = 5'(CELL - 1);

  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_FP   = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_BP   = 10'd48;
  localparam logic [9:0] H_SS   = H_VIS + H_FP;
  localparam logic [9:0] H_SE   = H_SS + H_SYNC;
  localparam logic [9:0] H_LAST = H_SE + H_BP - 10'd1;

  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_FP   = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_BP   = 10'd33;
  localparam logic [9:0] V_SS   = V_VIS + V_FP;
  localparam logic [9:0] V_SE   = V_SS + V_SYNC;
  localparam logic [9:0] V_LAST = V_SE + V_BP - 10'd1;

  localparam logic [11:0] C_BG   = 12'h000;
  localparam logic [11:0] C_BODY = 12'h0F0;
  localparam logic [11:0] C_HEAD = 12'hFF0;
  localparam logic [11:0] C_FOOD = 12'hF00;
  localparam logic [11:0] C_DIE  = 12'h888;
  localparam logic [11:0] C_INIT = 12'h00F;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic head;
    logic food;
  } s1_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters, cell counters and raw sync/enable levels.
// Cell indices step without a divider and freeze in blanking.
module vga_timing
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] cell_x,
  output logic [4:0] cell_y,
  output logic       de,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       frame_start
);

  logic [9:0] h_cnt, v_cnt, h_n, v_n;
  logic [4:0] sx, sy, sx_n, sy_n, cx_n, cy_n;
  logic       h_wrap, v_wrap;

  always_comb begin
    h_wrap = h_cnt == H_LAST;
    v_wrap = v_cnt == V_LAST;
    h_n    = h_wrap ? '0 : h_cnt + 10'd1;
    v_n    = v_cnt;
    sx_n   = sx;
    sy_n   = sy;
    cx_n   = cell_x;
    cy_n   = cell_y;
    if (h_wrap) begin
      sx_n = '0;
      cx_n = '0;
      v_n  = v_wrap ? '0 : v_cnt + 10'd1;
      if (v_wrap) begin
        sy_n = '0;
        cy_n = '0;
      end else if (v_cnt < V_VIS - 10'd1) begin
        sy_n = (sy == CELL_LAST) ? '0 : sy + 5'd1;
        cy_n = (sy == CELL_LAST) ? cell_y + 5'd1 : cell_y;
      end
    end else if (h_cnt < H_VIS - 10'd1) begin
      sx_n = (sx == CELL_LAST) ? '0 : sx + 5'd1;
      cx_n = (sx == CELL_LAST) ? cell_x + 5'd1 : cell_x;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      sx          <= '0;
      sy          <= '0;
      cell_x      <= '0;
      cell_y      <= '0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_n;
      v_cnt       <= v_n;
      sx          <= sx_n;
      sy          <= sy_n;
      cell_x      <= cx_n;
      cell_y      <= cy_n;
      frame_start <= (h_n == '0) && (v_n == V_VIS);
    end
  end

  assign de     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vs_raw = !((v_cnt >= V_SS) && (v_cnt < V_SE));

endmodule

// File: rtl/vga_render.sv
// Occupancy-grid reader: bitmap fetch, overlay and palette.
// Two registered stages keep RGB and syncs aligned at the pins.
module vga_render
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  game_state,
  input  logic [4:0]  head_x,
  input  logic [4:0]  head_y,
  input  logic [4:0]  food_x,
  input  logic [4:0]  food_y,
  output logic [9:0]  occ_addr,
  input  logic        occ_data,
  output logic        frame_start,
  output logic [11:0] vga,
  output logic        h_sync,
  output logic        v_sync
);

  logic [4:0]  cell_x, cell_y;
  logic        de, hs_raw, vs_raw;
  state_t      state_q;
  s1_t         s1;
  logic [11:0] pix, head_c, body_c;

  vga_timing u_timing (
    .clk         (clk),
    .rst         (rst),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .de          (de),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_start (frame_start)
  );

  // RAM returns this cell's bit in the cycle stage 1 is valid
  assign occ_addr = {cell_y, cell_x};

  always_comb begin
    head_c = (state_q == ST_DIE) ? C_DIE : C_HEAD;
    body_c = (state_q == ST_DIE) ? C_DIE : C_BODY;
    pix    = C_BG;
    priority case (1'b1)
      !s1.de:                pix = '0;
      state_q == ST_INITIAL: pix = C_INIT;
      s1.food:               pix = C_FOOD;
      s1.head:               pix = head_c;
      occ_data:              pix = body_c;
      default:               pix = C_BG;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INITIAL;
      s1      <= '{de: 1'b0, hs: 1'b1, vs: 1'b1,
                   head: 1'b0, food: 1'b0};
      vga     <= '0;
      h_sync  <= 1'b1;
      v_sync  <= 1'b1;
    end else begin
      if (frame_start)
        state_q <= state_t'(game_state);
      s1.de   <= de;
      s1.hs   <= hs_raw;
      s1.vs   <= vs_raw;
      s1.head <= (cell_x == head_x) && (cell_y == head_y);
      s1.food <= (cell_x == food_x) && (cell_y == food_y);
      vga     <= pix;
      h_sync  <= s1.hs;
      v_sync  <= s1.vs;
    end
  end

endmodule

// File: tb/tb_vga_render.sv
// Bench for vga_render: per-pixel scoreboard plus directed
// sync, address, state-latch and mid-frame reset steps.
module tb_vga_render;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  game_state;
  logic [4:0]  head_x, head_y, food_x, food_y;
  logic [9:0]  occ_addr;
  logic        occ_data = 1'b0;
  logic        frame_start;
  logic [11:0] vga;
  logic        h_sync, v_sync;

  logic        mem [0:1023];
  int          vectors = 0;
  int          miscompares = 0;
  int          m_h, m_v;
  logic [1:0]  m_state;
  bit          chk_en = 1'b0;
  logic [13:0] q [$];
  logic [13:0] sb_exp;
  int          fall1, rise1, fall2;
  logic        prev_hs;

  vga_render dut (
    .clk         (clk),
    .rst         (rst),
    .game_state  (game_state),
    .head_x      (head_x),
    .head_y      (head_y),
    .food_x      (food_x),
    .food_y      (food_y),
    .occ_addr    (occ_addr),
    .occ_data    (occ_data),
    .frame_start (frame_start),
    .vga         (vga),
    .h_sync      (h_sync),
    .v_sync      (v_sync)
  );

  always #20 clk = ~clk;

  // synchronous bitmap RAM, one cycle read latency
  always @(posedge clk) occ_data <= mem[occ_addr];

  function automatic logic [13:0] model(input int h, input int v);
    logic [11:0] c;
    int cx, cy;
    c = 12'h000;
    if (h < 640 && v < 480) begin
      cx = h / 20;
      cy = v / 20;
      if (m_state == 2'b10)
        c = 12'h00F;
      else if (int'(food_x) == cx && int'(food_y) == cy)
        c = 12'hF00;
      else if (int'(head_x) == cx && int'(head_y) == cy)
        c = (m_state == 2'b01) ? 12'h888 : 12'hFF0;
      else if (mem[cy * 32 + cx])
        c = (m_state == 2'b01) ? 12'h888 : 12'h0F0;
    end
    return {c, !(h >= 656 && h < 752), !(v >= 490 && v < 492)};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // called between a negedge and the first posedge after release
  task automatic start_model();
    m_state = 2'b10;
    q.delete();
    q.push_back({12'h000, 1'b1, 1'b1});
    q.push_back(model(0, 0));
    m_h = 1;
    m_v = 0;
    chk_en = 1'b1;
  endtask

  task automatic wait_pos(input int h, input int v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 500000 && !hit; i++) begin
      @(posedge clk);
      hit = (m_h == h) && (m_v == v);
    end
    vectors++;
    assert (hit) else begin
      miscompares++;
      $error("FAIL wait_pos observed=timeout expected=h%0d_v%0d", h, v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      assert (frame_start === (m_h == 0 && m_v == 480)) else begin
        miscompares++;
        $error("FAIL frame_start h=%0d v=%0d observed=%b",
               m_h, m_v, frame_start);
      end
      q.push_back(model(m_h, m_v));
      sb_exp = q.pop_front();
      vectors++;
      assert ({vga, h_sync, v_sync} === sb_exp) else begin
        miscompares++;
        $error("FAIL pixel h=%0d v=%0d observed=%h/%b%b expected=%h/%b%b",
               m_h, m_v, vga, h_sync, v_sync,
               sb_exp[13:2], sb_exp[1], sb_exp[0]);
      end
      if (m_h == 0 && m_v == 480)
        m_state = game_state;
      if (m_h == 799) begin
        m_h = 0;
        m_v = (m_v == 524) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
  end

  initial begin
    foreach (mem[i]) mem[i] = 1'b0;
    mem[3 * 32 + 5] = 1'b1;
    rst        = 1'b1;
    game_state = 2'b00;
    head_x     = 5'd0;
    head_y     = 5'd0;
    food_x     = 5'd31;
    food_y     = 5'd23;
    #1;
    check("rst_vga", int'(vga), 0);
    check("rst_hs", int'(h_sync), 1);
    check("rst_vs", int'(v_sync), 1);
    check("rst_fs", int'(frame_start), 0);
    check("rst_addr", int'(occ_addr), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #5;
    rst = 1'b0;
    start_model();

    fall1 = 0;
    rise1 = 0;
    fall2 = 0;
    prev_hs = h_sync;
    for (int k = 1; k <= 1700; k++) begin
      @(posedge clk);
      #1;
      if (k == 19)  check("addr_x0_end", int'(occ_addr), 0);
      if (k == 20)  check("addr_x1", int'(occ_addr), 1);
      if (k == 639) check("addr_x31", int'(occ_addr), 31);
      if (k == 700) check("addr_hblank", int'(occ_addr), 31);
      if (k == 800) check("addr_line1", int'(occ_addr), 0);
      if (prev_hs && !h_sync) begin
        if (fall1 == 0) fall1 = k;
        else if (fall2 == 0) fall2 = k;
      end
      if (!prev_hs && h_sync && rise1 == 0) rise1 = k;
      prev_hs = h_sync;
    end
    check("hs_first_fall", fall1, 658);
    check("hs_width", rise1 - fall1, 96);
    check("hs_period", fall2 - fall1, 800);

    wait_pos(0, 20);
    #1;
    check("addr_line20", int'(occ_addr), 32);
    wait_pos(639, 479);
    #1;
    check("addr_line479", int'(occ_addr), 767);

    // frame 2 runs normal colours; DIE requested mid-frame
    wait_pos(0, 200);
    #1;
    game_state = 2'b01;
    wait_pos(10, 480);
    #1;
    head_x = 5'd7;
    head_y = 5'd7;
    food_x = 5'd7;
    food_y = 5'd7;
    mem[7 * 32 + 7] = 1'b1;

    // frame 3 shows DIE tint; reset lands in frame 4
    wait_pos(0, 300);
    wait_pos(300, 100);
    #5;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_vga", int'(vga), 0);
    check("mid_rst_hs", int'(h_sync), 1);
    check("mid_rst_vs", int'(v_sync), 1);
    check("mid_rst_addr", int'(occ_addr), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #5;
    rst = 1'b0;
    start_model();
    fall1 = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (!h_sync && fall1 == 0) fall1 = k;
    end
    check("mid_rst_hs_fall", fall1, 658);
    repeat (200) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
